alu_muldiv: RTL

- Parametrised successor to the 32-bit combinational ALU; used in the EX stage of the MIPS datapath.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SLTU/XOR) are registered with a one-cycle latency.
- Adds iterative MULT/MULTU/DIV/DIVU into architectural HI/LO registers, plus MFHI/MFLO reads.
- Multi-cycle ops use a start/busy/done handshake; the hazard unit stalls the pipeline on busy.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_muldiv_iter.sv | 72 +++++++
 rtl/alu_muldiv.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide:
// op codes, FSM states and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLTU  = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_MULT  = 4'b1001,
    OP_MULTU = 4'b1010,
    OP_DIV   = 4'b1011,
    OP_XOR   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_MFHI  = 4'b1110,
    OP_MFLO  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// Operands arrive already made non-negative; sign handling lives in the top.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] raw_hi,
  output logic [WIDTH-1:0] raw_lo,
  output logic             last_step
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dreg;
  logic [CNT_W-1:0] cnt;
  logic             div_mode;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // acc:qreg is the product (multiplier shifts out of qreg) or remainder:quotient
  always_comb begin
    mul_sum   = {1'b0, acc} + (qreg[0] ? {1'b0, dreg} : '0);
    div_shift = {acc, qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dreg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      qreg     <= '0;
      dreg     <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      qreg     <= opa;
      dreg     <= opb;
      cnt      <= '0;
      div_mode <= is_div;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_mode) begin
        if (!div_diff[WIDTH]) begin
          acc  <= div_diff[WIDTH-1:0];
          qreg <= {qreg[WIDTH-2:0], 1'b1};
        end else begin
          acc  <= div_shift[WIDTH-1:0];
          qreg <= {qreg[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc  <= mul_sum[WIDTH:1];
        qreg <= {mul_sum[0], qreg[WIDTH-1:1]};
      end
    end
  end

  assign raw_hi    = acc;
  assign raw_lo    = qreg;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: registered single-cycle ops plus iterative MULT/DIV into HI/LO
// with a start/busy/done handshake.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state, next_state;
  op_e    opc;

  logic [WIDTH-1:0]   sum_ab, diff_ab, alu_res;
  logic               alu_ovf;
  logic               md_op, div_op, signed_op, div_by_zero;
  logic               launch, quick;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               iter_load, iter_step, last_step;
  logic [WIDTH-1:0]   raw_hi, raw_lo;
  logic               is_div_q, neg_q, rem_neg_q;
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign opc         = op_e'(op);
  assign sum_ab      = a + b;
  assign diff_ab     = a - b;
  assign md_op       = is_muldiv(op);
  assign div_op      = (opc == OP_DIV) || (opc == OP_DIVU);
  assign signed_op   = (opc == OP_MULT) || (opc == OP_DIV);
  assign div_by_zero = div_op && (b == '0);
  assign launch      = (state == S_IDLE) && start && md_op && !div_by_zero;
  assign quick       = (state == S_IDLE) && start && !launch;
  assign abs_a       = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b       = (signed_op && b[WIDTH-1]) ? -b : b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opc)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD: begin
        alu_res = sum_ab;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ab;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (iter_load),
    .step      (iter_step),
    .is_div    (div_op),
    .opa       (abs_a),
    .opb       (abs_b),
    .raw_hi    (raw_hi),
    .raw_lo    (raw_lo),
    .last_step (last_step)
  );

  // Remainder follows the dividend's sign; quotient/product follow sign_a ^ sign_b
  always_comb begin
    prod     = {raw_hi, raw_lo};
    prod_neg = -prod;
    if (is_div_q) begin
      fix_hi = rem_neg_q ? -raw_hi : raw_hi;
      fix_lo = neg_q ? -raw_lo : raw_lo;
    end else begin
      fix_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
      fix_lo = neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (launch) next_state = S_ITER;
      S_ITER:  if (last_step) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    iter_load = launch;
    iter_step = (state == S_ITER);
  end

  // Divide-by-zero bypasses the iterator entirely and completes like a single-cycle op
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (quick) begin
        done <= 1'b1;
        if (div_by_zero) begin
          hi     <= a;
          lo     <= '1;
          result <= '1;
          zero   <= 1'b0;
          ovf    <= 1'b0;
        end else begin
          result <= alu_res;
          zero   <= (alu_res == '0);
          ovf    <= alu_ovf;
        end
      end
      if (launch) begin
        is_div_q  <= div_op;
        neg_q     <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        rem_neg_q <= signed_op && a[WIDTH-1];
      end
      if (state == S_FIX) begin
        hi     <= fix_hi;
        lo     <= fix_lo;
        result <= fix_lo;
        zero   <= (fix_lo == '0);
        ovf    <= 1'b0;
        done   <= 1'b1;
      end
    end
  end

endmodule
